// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game controller slice.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 30;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button, followed by a registered
// rising-edge pulse (pulse lands 3 cycles after the input rises).
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-level match sequencer: state machine, score keeping and one
// req/ack motion update per video frame.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int CNT_W        = 8
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               start_btn,
    input  logic               update_ack,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               update_req,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               paddles_en,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [2:0]         game_state,
    output logic               winner,
    output logic               frame_overrun
);

    localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic               dir_q, dir_d;
    logic               winner_q, winner_d;
    logic               req_q, req_d;
    logic               ovr_q, ovr_d;
    logic               ball_reset_q, ball_reset_d;
    logic               start_pulse;

    btn_sync_edge u_start_sync (
        .clk    (pixel_clk),
        .rst_n  (reset),
        .btn_in (start_btn),
        .pulse  (start_pulse)
    );

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] s
    );
        return (s >= WIN) ? WIN : s + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_a_d    = score_a_q;
        score_b_d    = score_b_q;
        dir_d        = dir_q;
        winner_d     = winner_q;
        req_d        = req_q;
        ovr_d        = ovr_q;
        ball_reset_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_pulse) begin
                    score_a_d    = '0;
                    score_b_d    = '0;
                    dir_d        = DIR_RIGHT;
                    cnt_d        = SERVE_LD;
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_start) begin
                    if (cnt_q == '0) state_d = ST_PLAY;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_PLAY: begin
                // a frame arriving with the previous update unfinished is flagged, not queued
                if (frame_start && req_q)  ovr_d = 1'b1;
                if (frame_start && !req_q) req_d = 1'b1;
                if (req_q && update_ack) begin
                    req_d = 1'b0;
                    if (miss_left && !miss_right) begin
                        score_b_d = sat_inc(score_b_q);
                        dir_d     = DIR_LEFT;
                    end else if (miss_right && !miss_left) begin
                        score_a_d = sat_inc(score_a_q);
                        dir_d     = DIR_RIGHT;
                    end
                    if (miss_left || miss_right) begin
                        cnt_d   = POINT_LD;
                        state_d = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (frame_start) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (score_a_q == WIN || score_b_q == WIN) begin
                        winner_d = (score_b_q == WIN);
                        state_d  = ST_GAME_OVER;
                    end else begin
                        cnt_d        = SERVE_LD;
                        ball_reset_d = 1'b1;
                        state_d      = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            score_a_q    <= '0;
            score_b_q    <= '0;
            dir_q        <= DIR_RIGHT;
            winner_q     <= 1'b0;
            req_q        <= 1'b0;
            ovr_q        <= 1'b0;
            ball_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            dir_q        <= dir_d;
            winner_q     <= winner_d;
            req_q        <= req_d;
            ovr_q        <= ovr_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    assign update_req    = req_q;
    assign ball_reset    = ball_reset_q;
    assign serve_dir     = dir_q;
    assign paddles_en    = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign score_a       = score_a_q;
    assign score_b       = score_b_q;
    assign game_state    = state_q;
    assign winner        = winner_q;
    assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized scoreboard bench for pong_game_ctrl against a
// frame-counting match model.
module tb_pong_game_ctrl;

    localparam int SERVE_N = 60;
    localparam int POINT_N = 30;
    localparam int WIN_N   = 9;
    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_OVER  = 4;

    logic       pixel_clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b0;
    logic       update_ack = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       update_req, ball_reset, serve_dir, paddles_en;
    logic [3:0] score_a, score_b;
    logic [2:0] game_state;
    logic       winner, frame_overrun;

    pong_game_ctrl dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .start_btn     (start_btn),
        .update_ack    (update_ack),
        .miss_left     (miss_left),
        .miss_right    (miss_right),
        .update_req    (update_req),
        .ball_reset    (ball_reset),
        .serve_dir     (serve_dir),
        .paddles_en    (paddles_en),
        .score_a       (score_a),
        .score_b       (score_b),
        .game_state    (game_state),
        .winner        (winner),
        .frame_overrun (frame_overrun)
    );

    always #20 pixel_clk = ~pixel_clk;

    typedef struct {
        int st;
        int sa;
        int sb;
        int dir;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    // abstract match model
    int m_state = S_IDLE;
    int m_sa = 0, m_sb = 0, m_dir = 1, m_win = 0, m_frames = 0;
    int exp_br = 0, exp_reqs = 0;

    // monitor-side observations
    int br_count = 0, req_rises = 0;
    int prev_st = 0;
    bit prev_req = 0;
    exp_t e;

    function automatic void check(string nm, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void enter(int st);
        m_state  = st;
        m_frames = 0;
        exp_q.push_back('{st, m_sa, m_sb, m_dir, m_win});
        if (st == S_SERVE) exp_br++;
    endfunction

    function automatic void model_start();
        if (m_state == S_IDLE || m_state == S_OVER) begin
            m_sa  = 0;
            m_sb  = 0;
            m_dir = 1;
            enter(S_SERVE);
        end
    endfunction

    function automatic void model_frame();
        if (m_state == S_SERVE) begin
            m_frames++;
            if (m_frames == SERVE_N) enter(S_PLAY);
        end else if (m_state == S_POINT) begin
            m_frames++;
            if (m_frames == POINT_N) begin
                if (m_sa == WIN_N || m_sb == WIN_N) begin
                    m_win = (m_sb == WIN_N) ? 1 : 0;
                    enter(S_OVER);
                end else begin
                    enter(S_SERVE);
                end
            end
        end
    endfunction

    function automatic void model_ack(bit ml, bit mr);
        if (ml && !mr) begin
            if (m_sb < WIN_N) m_sb++;
            m_dir = 0;
        end else if (mr && !ml) begin
            if (m_sa < WIN_N) m_sa++;
            m_dir = 1;
        end
        if (ml || mr) enter(S_POINT);
    endfunction

    always @(negedge pixel_clk) begin
        if (!reset) begin
            prev_st  = 0;
            prev_req = 0;
        end else begin
            if (update_req && !prev_req) req_rises++;
            prev_req = update_req;
            if (ball_reset) br_count++;
            if (int'(game_state) != prev_st) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_state_change", int'(game_state), prev_st);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_state", int'(game_state), e.st);
                    check("sb_score_a", int'(score_a), e.sa);
                    check("sb_score_b", int'(score_b), e.sb);
                    check("sb_serve_dir", int'(serve_dir), e.dir);
                    check("sb_paddles_en", int'(paddles_en),
                          (e.st == S_SERVE || e.st == S_PLAY) ? 1 : 0);
                    if (e.st == S_OVER) check("sb_winner", int'(winner), e.win);
                    if (e.st == S_SERVE) check("sb_ball_reset", int'(ball_reset), 1);
                end
                prev_st = int'(game_state);
            end
        end
    end

    task automatic send_frame();
        @(negedge pixel_clk);
        model_frame();
        frame_start = 1'b1;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        check("frame_state", int'(game_state), m_state);
        repeat ($urandom_range(1, 6)) @(negedge pixel_clk);
    endtask

    task automatic play_frame(bit ml, bit mr, int d);
        @(negedge pixel_clk);
        frame_start = 1'b1;
        exp_reqs++;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        check("req_rise", int'(update_req), 1);
        for (int i = 0; i < d; i++) begin
            @(negedge pixel_clk);
            check("req_hold", int'(update_req), 1);
        end
        model_ack(ml, mr);
        update_ack = 1'b1;
        miss_left  = ml;
        miss_right = mr;
        @(negedge pixel_clk);
        update_ack = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        check("req_drop", int'(update_req), 0);
        repeat ($urandom_range(1, 4)) @(negedge pixel_clk);
    endtask

    task automatic stray_ack();
        @(negedge pixel_clk);
        update_ack = 1'b1;
        miss_left  = 1'($urandom_range(0, 1));
        miss_right = 1'b1;
        @(negedge pixel_clk);
        update_ack = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        @(negedge pixel_clk);
        check("stray_ack_no_req", int'(update_req), 0);
    endtask

    task automatic press_start(int hold);
        @(negedge pixel_clk);
        model_start();
        start_btn = 1'b1;
        repeat (hold) @(negedge pixel_clk);
        start_btn = 1'b0;
        repeat (6) @(negedge pixel_clk);
    endtask

    task automatic point_and_serve();
        repeat (POINT_N) send_frame();
        if (m_state == S_SERVE) repeat (SERVE_N) send_frame();
    endtask

    initial begin
        int guard;
        bit ml, mr;
        repeat (3) @(negedge pixel_clk);
        check("rst_update_req", int'(update_req), 0);
        check("rst_ball_reset", int'(ball_reset), 0);
        check("rst_serve_dir", int'(serve_dir), 1);
        check("rst_paddles_en", int'(paddles_en), 0);
        check("rst_scores", int'({score_a, score_b}), 0);
        check("rst_state", int'(game_state), S_IDLE);
        check("rst_winner", int'(winner), 0);
        check("rst_overrun", int'(frame_overrun), 0);
        @(negedge pixel_clk);
        reset = 1'b1;
        repeat (5) @(negedge pixel_clk);

        press_start(100);
        check("one_ball_reset", br_count, exp_br);
        repeat (SERVE_N) send_frame();

        play_frame(0, 0, 5);
        play_frame(0, 0, 0);
        repeat (4) play_frame(0, 0, $urandom_range(0, 5));
        check("req_per_frame", req_rises, exp_reqs);
        check("no_overrun", int'(frame_overrun), 0);

        play_frame(1, 0, $urandom_range(0, 4));
        repeat (POINT_N) send_frame();
        press_start(10);
        repeat (SERVE_N) send_frame();
        play_frame(1, 1, 2);
        point_and_serve();

        // ack withheld across a second frame_start
        @(negedge pixel_clk);
        frame_start = 1'b1;
        exp_reqs++;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        repeat (3) @(negedge pixel_clk);
        frame_start = 1'b1;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        check("overrun_set", int'(frame_overrun), 1);
        check("overrun_req_held", int'(update_req), 1);
        repeat (2) @(negedge pixel_clk);
        update_ack = 1'b1;
        @(negedge pixel_clk);
        update_ack = 1'b0;
        check("overrun_req_drop", int'(update_req), 0);
        repeat (4) @(negedge pixel_clk);
        check("overrun_no_dup", req_rises, exp_reqs);
        play_frame(0, 0, 1);
        check("overrun_sticky", int'(frame_overrun), 1);

        guard = 0;
        while (m_state != S_OVER && guard < 40) begin
            guard++;
            repeat ($urandom_range(0, 2)) play_frame(0, 0, $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) stray_ack();
            ml = (m_sb < 7) && ($urandom_range(0, 3) == 0);
            mr = !ml;
            play_frame(ml, mr, $urandom_range(0, 5));
            point_and_serve();
        end
        check("reached_game_over", int'(game_state), S_OVER);
        check("over_winner", int'(winner), 0);
        check("over_score_a", int'(score_a), WIN_N);
        stray_ack();
        repeat (3) send_frame();
        check("over_hold_a", int'(score_a), m_sa);
        check("over_hold_b", int'(score_b), m_sb);
        check("over_overrun_sticky", int'(frame_overrun), 1);

        press_start(20);
        repeat (SERVE_N) send_frame();
        play_frame(1, 0, 1);
        point_and_serve();
        check("q_empty_before_reset", exp_q.size(), 0);

        // reset while a request is pending
        @(negedge pixel_clk);
        frame_start = 1'b1;
        exp_reqs++;
        @(negedge pixel_clk);
        frame_start = 1'b0;
        check("pre_reset_req", int'(update_req), 1);
        @(posedge pixel_clk);
        #2 reset = 1'b0;
        #1;
        check("async_update_req", int'(update_req), 0);
        check("async_state", int'(game_state), S_IDLE);
        check("async_scores", int'({score_a, score_b}), 0);
        check("async_serve_dir", int'(serve_dir), 1);
        check("async_paddles_en", int'(paddles_en), 0);
        check("async_ball_reset", int'(ball_reset), 0);
        check("async_winner", int'(winner), 0);
        check("async_overrun", int'(frame_overrun), 0);
        m_state = S_IDLE;
        m_sa    = 0;
        m_sb    = 0;
        m_dir   = 1;
        m_win   = 0;
        repeat (3) @(negedge pixel_clk);
        reset = 1'b1;
        repeat (5) send_frame();
        stray_ack();
        check("post_reset_idle", int'(game_state), S_IDLE);
        check("post_reset_no_req", req_rises, exp_reqs);
        check("ball_reset_total", br_count, exp_br);
        check("q_empty_end", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-level game sequencer for the ping-pong VGA design.
- Runs the match state machine (idle, serve, play, point, game over) and keeps the score.
- Issues one ball/paddle update request per video frame to the motion datapath using a req/ack handshake.
- Sits between the VGA timing generator, which supplies frame_start, and the ball/paddle/drawing logic.

Parameters:
- SCORE_W, 4: width of each score counter.
- WIN_SCORE, 9: score that ends the match; must be less than 2^SCORE_W.
- SERVE_FRAMES, 60: frames the ball is held at centre before play starts.
- POINT_FRAMES, 30: frames of pause after a point.
- CNT_W, 8: frame countdown width; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- pixel_clk  in  1  pixel clock, 25 MHz.
- reset  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- start_btn  in  1  raw asynchronous start button, active-high.
- update_ack  in  1  datapath has finished the frame update.
- miss_left  in  1  ball passed Player A's edge; valid only when update_ack=1.
- miss_right  in  1  ball passed Player B's edge; valid only when update_ack=1.
- update_req  out  1  request one motion/collision update.
- ball_reset  out  1  one-cycle pulse: recentre ball and load velocity from serve_dir.
- serve_dir  out  1  0 = ball travels toward Player A (left), 1 = toward Player B (right).
- paddles_en  out  1  paddle movement allowed.
- score_a  out  SCORE_W  Player A score.
- score_b  out  SCORE_W  Player B score.
- game_state  out  3  current state encoding.
- winner  out  1  0 = A, 1 = B; valid in GAME_OVER.
- frame_overrun  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: update_req=0, ball_reset=0, serve_dir=1, paddles_en=0, scores=0, game_state=IDLE, winner=0, frame_overrun=0.
  - Internal: countdown=0, synchronizer flops=0.
  - Reset mid-handshake drops the pending request. No ack is expected afterwards.
- start_btn handling:
  - Passes through a 2-flop synchronizer and rising-edge detector, giving start_pulse.
  - start_pulse appears 3 cycles after the input rises.
  - Holding the button produces one pulse only.
- States and transitions:
  - IDLE: paddles_en=0. On start_pulse: clear scores, serve_dir=1, go to SERVE.
  - SERVE:
    - ball_reset pulses in the first cycle of the state.
    - Load countdown with SERVE_FRAMES-1 on entry; decrement on each frame_start.
    - At frame_start with countdown=0, go to PLAY.
    - paddles_en=1.
  - PLAY:
    - paddles_en=1.
    - frame_start at cycle n with no request pending: update_req=1 from cycle n+1, held until the cycle in which update_ack=1.
    - update_req is 0 the cycle after the ack.
    - An ack in the same cycle update_req rises is legal.
    - update_ack while update_req=0 is ignored.
    - miss_left/miss_right are sampled only in the ack cycle:
      - miss_left only: score_b+1, serve_dir=0 (serve toward the loser A), go to POINT.
      - miss_right only: score_a+1, serve_dir=1, go to POINT.
      - Both: no score change, serve_dir unchanged, go to POINT.
      - Neither: stay in PLAY.
    - frame_start while update_req=1: frame_overrun=1 (sticky until reset). No second request is queued; the pending request continues.
  - POINT:
    - paddles_en=0. Load countdown with POINT_FRAMES-1; decrement on frame_start.
    - At expiry: if score_a==WIN_SCORE or score_b==WIN_SCORE, go to GAME_OVER with winner latched. Otherwise go to SERVE.
  - GAME_OVER:
    - paddles_en=0; scores and winner held.
    - On start_pulse: clear scores, serve_dir=1, go to SERVE.
- Score rules:
  - Increments saturate at WIN_SCORE; no wrap-around.
  - Scores change only in the PLAY ack cycle or on a new-game clear.
- start_pulse is ignored in SERVE, PLAY and POINT.
- A frame_start coinciding with a state entry counts toward the new state's countdown only from the next frame_start.

Decomposition:
- Shared package pong_pkg holds:
  - State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
  - Constants DIR_LEFT=0, DIR_RIGHT=1.
  - Default SERVE_FRAMES and POINT_FRAMES.
- One sub-module, btn_sync_edge: 2-flop synchronizer plus rising-edge pulse. It is reused later for the paddle buttons.

Test Plan:
- Reset release, then start_btn held high for 100 cycles -> exactly one ball_reset pulse, game_state=SERVE, scores 0/0, serve_dir=1; PLAY entered on the 60th frame_start.
- In PLAY, frame_start pulses; ack after 5 cycles, then ack in the same cycle update_req rises -> update_req high from frame_start+1 until the ack cycle inclusive, exactly one request per frame, frame_overrun stays 0.
- Ack with miss_left=1 -> score_b increments 0->1, serve_dir=0, POINT for 30 frames, then SERVE with a ball_reset pulse. Repeat with miss_left and miss_right both 1 -> scores unchanged, serve_dir unchanged.
- Ack withheld across two frame_start pulses -> frame_overrun=1 and stays 1; update_req stays high with no duplicate; a later ack completes normally.
- Drive score_a to 9 via nine miss_right acks -> GAME_OVER, winner=0, score_a held at 9. A further miss in any state does not change scores. start_btn then clears scores and enters SERVE.
- Assert reset while update_req=1 in PLAY -> all outputs return to reset values immediately (asynchronously). After release the block is in IDLE, and no request is issued until a new game starts.
